// File: rtl/instr_queue.sv
// Fetch-to-decode instruction buffer: circular queue of {pc, instr, err} entries
// with registered occupancy, sticky overflow flag and flush on redirect.
module instr_queue #(
  parameter int                XLEN       = 32,
  parameter int                ADDR_WIDTH = 32,
  parameter int                DEPTH      = 2,
  parameter logic [XLEN-1:0]   NOP_INSTR  = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [ADDR_WIDTH-1:0]    in_pc_i,
  input  logic [XLEN-1:0]          in_instr_i,
  input  logic                     in_err_i,
  output logic                     fetch_stall_o,
  output logic                     out_valid_o,
  output logic [ADDR_WIDTH-1:0]    out_pc_o,
  output logic [XLEN-1:0]          out_instr_o,
  output logic                     out_err_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0]       r_instr_mem [DEPTH];
  logic                  r_err_mem   [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full/stall derive from registered occupancy only, so out_ready_i never reaches fetch_stall_o.
  assign w_push = in_valid_i && !flush_i && !w_full;
  assign w_pop  = !w_empty && out_ready_i && !flush_i;
  assign w_drop = in_valid_i && !flush_i && w_full;

  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (flush_i) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: every read is qualified by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= in_pc_i;
      r_instr_mem[r_wptr] <= in_instr_i;
      r_err_mem[r_wptr]   <= in_err_i;
    end
  end

  assign out_valid_o   = !w_empty;
  assign out_pc_o      = w_empty ? '0 : r_pc_mem[r_rptr];
  assign out_err_o     = w_empty ? 1'b0 : r_err_mem[r_rptr];
  assign out_instr_o   = (w_empty || r_err_mem[r_rptr]) ? NOP_INSTR : r_instr_mem[r_rptr];
  assign fetch_stall_o = w_full;
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the buffer contents.
module tb_instr_queue;

  localparam int          XLEN  = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i;
  logic                   in_valid_i;
  logic [AW-1:0]          in_pc_i;
  logic [XLEN-1:0]        in_instr_i;
  logic                   in_err_i;
  logic                   fetch_stall_o;
  logic                   out_valid_o;
  logic [AW-1:0]          out_pc_o;
  logic [XLEN-1:0]        out_instr_o;
  logic                   out_err_o;
  logic                   out_ready_i;
  logic [$clog2(DEPTH):0] count_o;
  logic                   overflow_o;

  instr_queue #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_instr_i(in_instr_i), .in_err_i(in_err_i),
    .fetch_stall_o(fetch_stall_o), .out_valid_o(out_valid_o), .out_pc_o(out_pc_o),
    .out_instr_o(out_instr_o), .out_err_o(out_err_o), .out_ready_i(out_ready_i),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0]   pc;
    logic [XLEN-1:0] instr;
    logic            err;
  } entry_t;

  entry_t mq[$];
  bit     movf;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit              v;
    logic [AW-1:0]   epc;
    logic [XLEN-1:0] ein;
    bit              eerr;
    v    = (mq.size() != 0);
    epc  = v ? mq[0].pc : '0;
    eerr = v ? mq[0].err : 1'b0;
    ein  = (!v || eerr) ? NOP : mq[0].instr;
    check("valid", 64'(out_valid_o), 64'(v));
    check("pc",    64'(out_pc_o),    64'(epc));
    check("instr", 64'(out_instr_o), 64'(ein));
    check("err",   64'(out_err_o),   64'(eerr));
    check("count", 64'(count_o),     64'(mq.size()));
    check("stall", 64'(fetch_stall_o), 64'(mq.size() == DEPTH));
    check("ovf",   64'(overflow_o),  64'(movf));
  endtask

  // Advance one clock: update the model from the inputs applied before the edge.
  task automatic cycle();
    bit do_pop, do_push, do_drop;
    entry_t e;
    if (flush_i) begin
      mq.delete();
      movf = 1'b0;
      $display("flush");
    end else begin
      do_pop  = (mq.size() != 0) && out_ready_i;
      do_push = in_valid_i && (mq.size() < DEPTH);
      do_drop = in_valid_i && (mq.size() == DEPTH);
      if (do_pop) begin
        e = mq.pop_front();
        $display("pop  pc=%h instr=%h err=%0d", e.pc, e.instr, e.err);
      end
      if (do_push) begin
        e.pc = in_pc_i; e.instr = in_instr_i; e.err = in_err_i;
        mq.push_back(e);
        $display("push pc=%h instr=%h err=%0d", e.pc, e.instr, e.err);
      end
      if (do_drop) begin
        movf = 1'b1;
        $display("drop pc=%h", in_pc_i);
      end
    end
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] pc, input logic [XLEN-1:0] ins,
                       input bit err, input bit rdy, input bit fl);
    in_valid_i = v; in_pc_i = pc; in_instr_i = ins; in_err_i = err;
    out_ready_i = rdy; flush_i = fl;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, '0, '0, 0, 0, 0);
    movf = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_instr", 64'(out_instr_o), 64'h13);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_stall", 64'(fetch_stall_o), 64'd0);
    check("rst_ovf",   64'(overflow_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    compare_all();

    // Single pass-through
    drive(1, 32'h100, 32'h0050_0093, 0, 1, 0);
    cycle();
    check("pt_valid", 64'(out_valid_o), 64'd1);
    check("pt_pc",    64'(out_pc_o), 64'h100);
    check("pt_instr", 64'(out_instr_o), 64'h0050_0093);
    drive(0, '0, '0, 0, 1, 0);
    cycle();
    check("pt_count", 64'(count_o), 64'd0);

    // Fill and backpressure
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i * 4), 32'h1000_0000 + 32'(i), 0, 0, 0);
      cycle();
      if (i == 1) begin
        check("fill_stall", 64'(fetch_stall_o), 64'd1);
        check("fill_count", 64'(count_o), 64'd2);
      end
    end
    check("fill_ovf", 64'(overflow_o), 64'd1);
    check("fill_head0", 64'(out_pc_o), 64'h0);
    drive(0, '0, '0, 0, 1, 0);
    cycle();
    check("fill_head1", 64'(out_pc_o), 64'h4);
    cycle();
    check("fill_empty", 64'(count_o), 64'd0);

    // Flush priority (clears the sticky overflow left over from above)
    drive(1, 32'h300, 32'h3, 0, 0, 0); cycle();
    drive(1, 32'h304, 32'h4, 0, 0, 0); cycle();
    drive(1, 32'h200, 32'h5, 0, 1, 1); cycle();
    check("fl_count", 64'(count_o), 64'd0);
    check("fl_valid", 64'(out_valid_o), 64'd0);
    check("fl_ovf",   64'(overflow_o), 64'd0);
    drive(0, '0, '0, 0, 1, 0); cycle();
    check("fl_nostore", 64'(out_valid_o), 64'd0);

    // Streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i * 4), 32'h2000_0000 + 32'(i), 0, 1, 0);
      cycle();
      check("str_pc", 64'(out_pc_o), 64'(i * 4));
    end
    drive(0, '0, '0, 0, 1, 0); cycle();

    // Error entry
    drive(1, 32'h40, 32'hFFFF_FFFF, 1, 0, 0); cycle();
    check("err_flag",  64'(out_err_o), 64'd1);
    check("err_instr", 64'(out_instr_o), 64'h13);
    check("err_pc",    64'(out_pc_o), 64'h40);
    drive(0, '0, '0, 0, 1, 0); cycle();
    check("err_popped", 64'(count_o), 64'd0);

    // Asynchronous reset with two entries held
    drive(1, 32'h500, 32'h6, 0, 0, 0); cycle();
    drive(1, 32'h504, 32'h7, 0, 0, 0); cycle();
    drive(0, '0, '0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    mq.delete(); movf = 1'b0;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_instr", 64'(out_instr_o), 64'h13);
    check("arst_stall", 64'(fetch_stall_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    compare_all();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 99) < 65), $urandom, $urandom,
            bit'($urandom_range(0, 99) < 15), bit'($urandom_range(0, 99) < 55),
            bit'($urandom_range(0, 99) < 5));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- 2-to-N entry instruction buffer between the fetch stage and the decode stage.
- Captures each valid (PC, instruction, bus-error) triple produced by fetch and presents it to decode with a valid/ready handshake.
- Decouples decode stalls from the instruction-memory Wishbone cycle.
- Flushed on a taken branch so wrong-path instructions never reach decode.

Parameters:
- XLEN, 32, instruction/data width.
- ADDR_WIDTH, 32, PC width.
- DEPTH, 2, number of entries; power of two, >= 2.
- NOP_INSTR, 32'h0000_0013, instruction presented on out_instr_o when empty or on an error entry (ADDI x0,x0,0).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  discard all entries (branch taken / redirect)
- in_valid_i  input  1  fetch has an instruction this cycle
- in_pc_i  input  ADDR_WIDTH  PC of incoming instruction
- in_instr_i  input  XLEN  incoming instruction word
- in_err_i  input  1  incoming word came from a Wishbone error response
- fetch_stall_o  output  1  queue full; fetch must hold
- out_valid_o  output  1  head entry valid for decode
- out_pc_o  output  ADDR_WIDTH  head entry PC
- out_instr_o  output  XLEN  head entry instruction
- out_err_o  output  1  head entry carries a fetch fault
- out_ready_i  input  1  decode accepts head entry this cycle
- count_o  output  $clog2(DEPTH)+1  current occupancy
- overflow_o  output  1  sticky: a push was dropped because the queue was full

Behaviour:
- Reset (rst_ni low, asynchronous):
  - count_o = 0, read/write pointers = 0.
  - out_valid_o = 0, out_pc_o = 0, out_instr_o = NOP_INSTR, out_err_o = 0.
  - fetch_stall_o = 0, overflow_o = 0.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Storage: circular buffer of DEPTH entries {pc, instr, err}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: push = in_valid_i && !flush_i && (count_o < DEPTH). The entry is written at wptr and wptr increments.
- Pop: pop = out_valid_o && out_ready_i && !flush_i. rptr increments.
- Simultaneous push and pop:
  - When 0 < count_o < DEPTH, count is unchanged and both pointers advance.
  - When full, push is not allowed: fetch_stall_o is based on registered occupancy, with no combinational path from out_ready_i.
- Latency: no bypass. An instruction pushed at edge N is visible on out_* after edge N (registered). Minimum 1 cycle, fetch-to-decode.
- Head outputs:
  - out_valid_o = (count_o != 0).
  - out_pc_o = head.pc when valid, else 0.
  - out_err_o = head.err when valid, else 0.
  - out_instr_o = NOP_INSTR when empty or when head.err = 1; otherwise head.instr.
- fetch_stall_o = (count_o == DEPTH). Combinational from registered state only.
- Overflow: if in_valid_i && count_o == DEPTH && !flush_i, the word is dropped and overflow_o is set. overflow_o clears only on reset or flush_i.
- Flush:
  - At the next edge: count = 0, pointers = 0, overflow_o = 0.
  - Takes priority over any same-cycle push or pop; the incoming word and the pop are both discarded.
  - out_valid_o = 0 in the cycle after the flush.
- count_o: 0..DEPTH, never exceeds DEPTH, never underflows. A pop on an empty queue is impossible because out_valid_o = 0.
- Error entries occupy a slot and pop normally. The queue itself takes no trap action.

Test Plan:
- Reset:
  - Stimulus: hold rst_ni low, then release.
  - Required: out_valid_o = 0, out_instr_o = 32'h00000013, count_o = 0, fetch_stall_o = 0, overflow_o = 0.
  - Drop rst_ni asynchronously with 2 entries held: all outputs return to reset values before the next edge.
- Single pass-through:
  - Stimulus: push pc = 0x100, instr = 0x00500093 with out_ready_i = 1.
  - Required: one cycle later out_valid_o = 1, out_pc_o = 0x100, out_instr_o = 0x00500093; next cycle count_o = 0.
- Fill and backpressure:
  - Stimulus: out_ready_i = 0, push 0x0, 0x4, 0x8.
  - Required: after two pushes fetch_stall_o = 1 and count_o = 2; the third word is dropped and overflow_o = 1.
  - Then raise out_ready_i: 0x0 then 0x4 emerge in order.
- Streaming with wrap:
  - Stimulus: continuous push/pop of 10 sequential PCs 0x0..0x24 with out_ready_i = 1.
  - Required: in-order output with no gaps after the first cycle; pointers wrap without loss or duplication.
- Flush priority:
  - Stimulus: with 2 entries held, assert flush_i together with in_valid_i (pc = 0x200) and out_ready_i = 1.
  - Required: next cycle count_o = 0, out_valid_o = 0, overflow_o = 0; 0x200 is not stored.
- Error entry:
  - Stimulus: push pc = 0x40 with in_err_i = 1 and instr = 0xFFFFFFFF.
  - Required: out_valid_o = 1, out_err_o = 1, out_instr_o = 0x00000013, out_pc_o = 0x40; pops normally.
